// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-requester ROM arbiter.
// Build option ROM_ARB_RR_EN selects round-robin over fixed priority.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int REQ_FETCH = 0;
    localparam int REQ_LOAD  = 1;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational grant selector: request vector (and last grant) to a one-hot grant.
// ROM_ARB_RR_EN defined: round-robin; undefined: requester 0 has fixed priority.
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic [1:0] req_valid,
`ifdef ROM_ARB_RR_EN
    input  logic       last_grant,
`endif
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
`ifdef ROM_ARB_RR_EN
        // Under contention the requester that did not win last time goes next.
        if (req_valid == 2'b11) begin
            grant = onehot(~last_grant);
        end else begin
            grant = req_valid;
        end
`else
        if (req_valid[REQ_FETCH]) begin
            grant = onehot(1'b0);
        end else if (req_valid[REQ_LOAD]) begin
            grant = onehot(1'b1);
        end
`endif
    end

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of a shared synchronous ROM (one read in flight).
// ROM_ARB_RR_EN defined: round-robin arbitration; undefined: fixed priority.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [1:0]                    req_valid,
    input  logic [1:0][ADDRESS_WIDTH-1:0] req_address,
    output logic [1:0]                    req_ready,
    output logic [1:0]                    rsp_valid,
    input  logic [1:0]                    rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rom_read_enable,
    output logic [ADDRESS_WIDTH-1:0]      rom_address,
    input  logic [DATA_WIDTH-1:0]         rom_data
);

    state_t                   state;
    logic                     grant_idx;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [1:0]               pick;
    logic                     pick_idx;
    logic                     accept;
`ifdef ROM_ARB_RR_EN
    logic                     last_grant;
`endif

    rom_arb_pick u_pick (
        .req_valid  (req_valid),
`ifdef ROM_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .grant      (pick)
    );

    assign pick_idx = pick[REQ_LOAD];

    // Accepting is gated by reset_n so nothing is granted while reset is held.
    assign accept          = reset_n && (state == IDLE) && (req_valid != 2'b00);
    assign req_ready       = accept ? pick : 2'b00;
    assign rom_read_enable = accept;
    assign rom_address     = accept ? req_address[pick_idx] : address_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            grant_idx <= 1'b0;
            address_q <= '0;
            rsp_data  <= '0;
            rsp_valid <= 2'b00;
`ifdef ROM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_idx <= pick_idx;
                        address_q <= req_address[pick_idx];
`ifdef ROM_ARB_RR_EN
                        last_grant <= pick_idx;
`endif
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    rsp_data  <= rom_data;
                    rsp_valid <= onehot(grant_idx);
                    state     <= HOLD;
                end
                HOLD: begin
                    // Only the granted requester's accept ends the transaction.
                    if (rsp_ready[grant_idx]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter with a behavioural ROM and arbitration model.
// Follows ROM_ARB_RR_EN the same way as the design (round-robin vs fixed priority).
module tb_rom_arbiter;

    logic            clock;
    logic            reset_n;
    logic [1:0]      req_valid;
    logic [1:0][7:0] req_address;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [7:0]      rsp_data;
    logic            rom_read_enable;
    logic [7:0]      rom_address;
    logic [7:0]      rom_data;

    typedef struct {
        logic       g;
        logic [7:0] data;
        int         acc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       me;
    logic       mg;
    logic       model_last;
    logic [7:0] rom_mem [256];
    logic [1:0] acc_seen;
    logic       mon_en;
    int         cycle;
    int         checks;
    int         errors;

    rom_arbiter #(
        .ADDRESS_WIDTH (8),
        .DATA_WIDTH    (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_address     (req_address),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rom_read_enable (rom_read_enable),
        .rom_address     (rom_address),
        .rom_data        (rom_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (rom_read_enable) rom_data <= rom_mem[rom_address];
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration rule: one valid requester always wins; on contention
    // round-robin alternates, fixed priority favours requester 0.
    function automatic logic model_pick(input logic [1:0] v);
`ifdef ROM_ARB_RR_EN
        if (v == 2'b11) return !model_last;
        return v[1];
`else
        return !v[0];
`endif
    endfunction

    always @(negedge clock) begin
        if (mon_en && reset_n) begin
            cycle++;
            acc_seen = req_ready;
            if (exp_q.size() == 0) begin
                check_output("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                if (req_valid != 2'b00) begin
                    mg = model_pick(req_valid);
                    check_output("grant", 32'(req_ready), 32'(mg ? 2'b10 : 2'b01));
                    check_output("rom_read_enable", 32'(rom_read_enable), 32'd1);
                    check_output("rom_address", 32'(rom_address), 32'(req_address[mg]));
                    exp_q.push_back('{mg, rom_mem[req_address[mg]], cycle});
                    model_last = mg;
                end else begin
                    check_output("idle_quiet", 32'({req_ready, rom_read_enable}), 32'd0);
                end
            end else begin
                me = exp_q[0];
                check_output("busy_quiet", 32'({req_ready, rom_read_enable}), 32'd0);
                if (cycle >= me.acc + 2) begin
                    check_output("rsp_valid", 32'(rsp_valid), 32'(me.g ? 2'b10 : 2'b01));
                    check_output("rsp_data", 32'(rsp_data), 32'(me.data));
                    if (rsp_ready[me.g]) void'(exp_q.pop_front());
                end else begin
                    check_output("wait_rsp_valid", 32'(rsp_valid), 32'd0);
                end
            end
        end else begin
            acc_seen = 2'b00;
        end
    end

    task automatic apply_stimulus(input int n, input int p_req, input int p_rdy);
        for (int c = 0; c < n; c++) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && acc_seen[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && ($urandom_range(0, 99) < p_req)) begin
                    req_valid[i]   = 1'b1;
                    req_address[i] = 8'($urandom);
                end
                rsp_ready[i] = ($urandom_range(0, 99) < p_rdy);
            end
        end
    endtask

    task automatic wait_accept(input int idx);
        int n;
        n = 0;
        while (!acc_seen[idx] && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        check_output("accept_timeout", 32'(acc_seen[idx]), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        check_output("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check_output({tag, "_rom_read_enable"}, 32'(rom_read_enable), 32'd0);
        check_output({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_output({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check_output({tag, "_rom_address"}, 32'(rom_address), 32'd0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cycle       = 0;
        mon_en      = 1'b0;
        model_last  = 1'b1;
        acc_seen    = 2'b00;
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
        rom_mem[8'h12] = 8'hA5;
        reset_n     = 1'b0;
        req_valid   = 2'b11;
        req_address = {8'h02, 8'h01};
        rsp_ready   = 2'b00;

        // Asynchronous reset takes effect before any clock edge.
        #3;
        check_reset_values("por");
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("por_held");
        req_valid = 2'b00;
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Single fetch of ROM[0x12].
        @(posedge clock);
        #1;
        req_valid      = 2'b01;
        req_address[0] = 8'h12;
        rsp_ready      = 2'b01;
        wait_accept(0);
        @(posedge clock);
        #1;
        req_valid = 2'b00;
        wait_idle();

        // Contention with both requesters held valid.
        @(posedge clock);
        #1;
        req_address = {8'h02, 8'h01};
        rsp_ready   = 2'b11;
        req_valid   = 2'b11;
        repeat (12) @(posedge clock);
        #1;
        req_valid = 2'b00;
        wait_idle();

        // Wrong-port accept while requester 1 is in HOLD, then the right one.
        @(posedge clock);
        #1;
        req_valid      = 2'b10;
        req_address[1] = 8'h44;
        rsp_ready      = 2'b01;
        wait_accept(1);
        @(posedge clock);
        #1;
        req_valid = 2'b00;
        repeat (6) @(posedge clock);
        #1;
        rsp_ready = 2'b10;
        wait_idle();

        // Reset pulse while the transaction is in WAIT.
        @(posedge clock);
        #1;
        req_valid      = 2'b10;
        req_address[1] = 8'h33;
        rsp_ready      = 2'b11;
        wait_accept(1);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        mon_en  = 1'b0;
        #1;
        check_reset_values("mid_wait");
        exp_q.delete();
        model_last = 1'b1;
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        wait_accept(1);
        @(posedge clock);
        #1;
        req_valid = 2'b00;
        wait_idle();

        // Randomized traffic with random backpressure.
        apply_stimulus(800, 40, 45);
        @(posedge clock);
        #1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        wait_idle();
        repeat (3) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 ADDRESS_WIDTH, default 8, width of each requester address and of rom_address.
REQ-002 DATA_WIDTH, default 8, width of rom_data and rsp_data.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  2  per-requester read request (bit 0 = fetch, bit 1 = load).
REQ-006 req_address  in  2 x ADDRESS_WIDTH  per-requester read address, packed [1:0].
REQ-007 req_ready  out  2  per-requester request accept strobe.
REQ-008 rsp_valid  out  2  per-requester response valid; at most one bit set.
REQ-009 rsp_ready  in  2  per-requester response accept.
REQ-010 rsp_data  out  DATA_WIDTH  shared response data; meaningful only while a rsp_valid bit is set.
REQ-011 rom_read_enable  out  1  read strobe to the shared synchronous ROM.
REQ-012 rom_address  out  ADDRESS_WIDTH  ROM address.
REQ-013 rom_data  in  DATA_WIDTH  ROM read data, valid one cycle after the edge that samples rom_read_enable=1.

Function
REQ-014 FSM states: IDLE, WAIT, HOLD; exactly one active.
REQ-015 IDLE, no req_valid: stay IDLE; req_ready=0, rom_read_enable=0.
REQ-016 IDLE, any req_valid: select grant g per REQ-022/REQ-023; same cycle req_ready[g]=1 (combinational), other bit 0, rom_read_enable=1, rom_address=req_address[g]; register g; go WAIT.
REQ-017 WAIT: req_ready=0, rom_read_enable=0; capture rom_data into rsp_data register on the closing edge; go HOLD.
REQ-018 HOLD: rsp_valid[g]=1, rsp_data stable; stay until rsp_ready[g]=1, then go IDLE; rsp_ready on the non-granted bit is ignored.
REQ-019 Latency: request accepted on edge N gives rsp_valid on cycle N+2; minimum 3 cycles per transaction; no overlap of transactions.
REQ-020 req_ready is 0 in WAIT and HOLD regardless of req_valid; pending requests wait without loss.
REQ-021 Requesters hold req_valid and req_address stable until req_ready; the block does not check this.
REQ-022 Arbitration with ROM_ARB_RR_EN: round-robin; both valid picks the requester not granted last; one valid always wins.
REQ-023 Arbitration without ROM_ARB_RR_EN: fixed priority, requester 0 wins whenever valid.
REQ-024 Addresses pass through unmodified; no range check.
REQ-025 rom_address holds its last value outside IDLE-grant cycles.

Reset
REQ-026 reset_n low asynchronously forces IDLE, rsp_valid=0, rsp_data=0, rom_address=0, last-grant register=1 (requester 0 wins first round-robin contest).
REQ-027 While reset_n is low, req_ready=0 and rom_read_enable=0 regardless of req_valid.
REQ-028 Reset mid-transaction (WAIT or HOLD) drops the transaction; no response is produced after reset release.
REQ-029 First request is accepted no earlier than the first rising edge after reset_n rises.

Configuration
REQ-030 Macro ROM_ARB_RR_EN defined: round-robin per REQ-022, last-grant register present.
REQ-031 ROM_ARB_RR_EN undefined: fixed priority per REQ-023, last-grant register absent; all other behaviour identical.

Structure
REQ-032 Shared package rom_arb_pkg holds the state enum (IDLE, WAIT, HOLD) and requester index constants REQ_FETCH=0, REQ_LOAD=1.
REQ-033 One sub-module rom_arb_pick: combinational grant selector (req_valid, last grant -> one-hot grant), with the ROM_ARB_RR_EN selection inside it.
REQ-034 The ROM itself is external; this block only drives its port.

Verification
REQ-035 Single fetch: req_valid=01, addr0=0x12, ROM[0x12]=0xA5 -> req_ready=01 same cycle, rom_read_enable one cycle, rsp_valid=01 with rsp_data=0xA5 two cycles later, cleared after rsp_ready=01.
REQ-036 Contention, RR: both valid, addr0=0x01, addr1=0x02 -> grants 0, then 1, then 0 over three transactions; without macro -> grant 0 every time while valid0 held.
REQ-037 Backpressure: rsp_ready=00 for 5 cycles in HOLD -> rsp_valid and rsp_data stable, req_ready=00, no rom_read_enable pulse.
REQ-038 Reset in WAIT: pull reset_n low for 1 cycle -> outputs at reset values immediately, no rsp_valid after release, next request served normally.
REQ-039 Wrong-port accept: HOLD for requester 1, drive rsp_ready=01 -> stays HOLD; rsp_ready=10 -> IDLE next cycle.
